// File: rtl/rob_core.sv
// 16-entry circular reorder buffer: in-order issue, out-of-order completion from ALU/LSB,
// in-order single commit per cycle, and full flush on a mispredicted branch commit.
module rob_core #(
  parameter int ROB_POS_WID = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic                   issue,
  input  logic [4:0]             issue_rd,
  input  logic [1:0]             issue_kind,
  input  logic                   issue_pred_jump,
  output logic                   full,
  output logic [ROB_POS_WID-1:0] tail_pos,
  input  logic [ROB_POS_WID-1:0] q1_pos,
  output logic                   q1_ready,
  output logic [31:0]            q1_val,
  input  logic [ROB_POS_WID-1:0] q2_pos,
  output logic                   q2_ready,
  output logic [31:0]            q2_val,
  input  logic                   alu_result,
  input  logic [ROB_POS_WID-1:0] alu_rob_pos,
  input  logic [31:0]            alu_val,
  input  logic                   alu_jump,
  input  logic [31:0]            alu_pc,
  input  logic                   lsb_result,
  input  logic [ROB_POS_WID-1:0] lsb_rob_pos,
  input  logic [31:0]            lsb_val,
  output logic                   commit,
  output logic [4:0]             commit_rd,
  output logic [31:0]            commit_val,
  output logic [ROB_POS_WID-1:0] commit_rob_pos,
  output logic                   commit_store,
  output logic                   rollback,
  output logic [31:0]            rollback_pc
);
  localparam int DEPTH = 2**ROB_POS_WID;
  localparam logic [1:0] KIND_STORE  = 2'd1;
  localparam logic [1:0] KIND_BRANCH = 2'd2;
  localparam logic [ROB_POS_WID:0]   CNT_FULL = {1'b1, {ROB_POS_WID{1'b0}}};
  localparam logic [ROB_POS_WID:0]   CNT_ONE  = {{ROB_POS_WID{1'b0}}, 1'b1};
  localparam logic [ROB_POS_WID-1:0] POS_ONE  = {{(ROB_POS_WID-1){1'b0}}, 1'b1};

  logic [DEPTH-1:0]        busy_q, busy_d, ready_q, ready_d;
  logic [DEPTH-1:0]        pj_q, pj_d, jump_q, jump_d;
  logic [DEPTH-1:0][4:0]   rd_q, rd_d;
  logic [DEPTH-1:0][1:0]   kind_q, kind_d;
  logic [DEPTH-1:0][31:0]  val_q, val_d, pc_q, pc_d;
  logic [ROB_POS_WID-1:0]  head_q, head_d, tail_q, tail_d;
  logic [ROB_POS_WID:0]    cnt_q, cnt_d;

  logic                    commit_q, commit_d, commit_store_q, commit_store_d;
  logic                    rollback_q, rollback_d;
  logic [4:0]              commit_rd_q, commit_rd_d;
  logic [31:0]             commit_val_q, commit_val_d, rollback_pc_q, rollback_pc_d;
  logic [ROB_POS_WID-1:0]  commit_pos_q, commit_pos_d;

  logic do_issue, do_commit;

  assign full     = (cnt_q == CNT_FULL);
  assign tail_pos = tail_q;

  // Operand lookup: a same-cycle broadcast beats stored state, ALU beats LSB.
  logic [1:0][ROB_POS_WID-1:0] qpos;
  logic [1:0]                  qrdy;
  logic [1:0][31:0]            qval;
  assign qpos = {q2_pos, q1_pos};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      qrdy[i] = ready_q[qpos[i]];
      qval[i] = val_q[qpos[i]];
      if (rdy && busy_q[qpos[i]]) begin
        if (lsb_result && lsb_rob_pos == qpos[i]) begin
          qrdy[i] = 1'b1;
          qval[i] = lsb_val;
        end
        if (alu_result && alu_rob_pos == qpos[i]) begin
          qrdy[i] = 1'b1;
          qval[i] = alu_val;
        end
      end
      if (!rst) begin
        qrdy[i] = 1'b0;
        qval[i] = '0;
      end
    end
  end

  assign q1_ready = qrdy[0];
  assign q1_val   = qval[0];
  assign q2_ready = qrdy[1];
  assign q2_val   = qval[1];

  always_comb begin
    busy_d = busy_q;  ready_d = ready_q;  pj_d = pj_q;  jump_d = jump_q;
    rd_d = rd_q;  kind_d = kind_q;  val_d = val_q;  pc_d = pc_q;
    head_d = head_q;  tail_d = tail_q;  cnt_d = cnt_q;
    commit_d = 1'b0;  commit_store_d = 1'b0;  rollback_d = 1'b0;
    commit_rd_d = commit_rd_q;  commit_val_d = commit_val_q;
    commit_pos_d = commit_pos_q;  rollback_pc_d = rollback_pc_q;
    do_issue  = 1'b0;
    do_commit = 1'b0;

    if (rdy) begin
      do_commit = busy_q[head_q] && ready_q[head_q];
      // full is sampled before this cycle's commit frees a slot
      do_issue  = issue && !full;

      if (lsb_result && busy_q[lsb_rob_pos]) begin
        ready_d[lsb_rob_pos] = 1'b1;
        val_d[lsb_rob_pos]   = lsb_val;
      end
      if (alu_result && busy_q[alu_rob_pos]) begin
        ready_d[alu_rob_pos] = 1'b1;
        val_d[alu_rob_pos]   = alu_val;
        jump_d[alu_rob_pos]  = alu_jump;
        pc_d[alu_rob_pos]    = alu_pc;
      end

      if (do_issue) begin
        busy_d[tail_q]  = 1'b1;
        ready_d[tail_q] = 1'b0;
        rd_d[tail_q]    = issue_rd;
        kind_d[tail_q]  = issue_kind;
        pj_d[tail_q]    = issue_pred_jump;
        tail_d          = tail_q + POS_ONE;
      end

      if (do_commit) begin
        busy_d[head_q]  = 1'b0;
        ready_d[head_q] = 1'b0;
        head_d          = head_q + POS_ONE;
        commit_rd_d     = rd_q[head_q];
        commit_val_d    = val_q[head_q];
        commit_pos_d    = head_q;
        if (kind_q[head_q] == KIND_STORE) commit_store_d = 1'b1;
        else                              commit_d       = 1'b1;
        if (kind_q[head_q] == KIND_BRANCH && jump_q[head_q] != pj_q[head_q]) begin
          rollback_d    = 1'b1;
          rollback_pc_d = pc_q[head_q];
        end
      end

      if (do_issue && !do_commit)      cnt_d = cnt_q + CNT_ONE;
      else if (!do_issue && do_commit) cnt_d = cnt_q - CNT_ONE;

      // Mispredict squashes everything in flight, including this cycle's issue and results.
      if (rollback_d) begin
        busy_d  = '0;
        ready_d = '0;
        head_d  = '0;
        tail_d  = '0;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;  ready_q <= '0;  pj_q <= '0;  jump_q <= '0;
      rd_q <= '0;  kind_q <= '0;  val_q <= '0;  pc_q <= '0;
      head_q <= '0;  tail_q <= '0;  cnt_q <= '0;
      commit_q <= 1'b0;  commit_store_q <= 1'b0;  rollback_q <= 1'b0;
      commit_rd_q <= '0;  commit_val_q <= '0;  commit_pos_q <= '0;  rollback_pc_q <= '0;
    end else begin
      busy_q <= busy_d;  ready_q <= ready_d;  pj_q <= pj_d;  jump_q <= jump_d;
      rd_q <= rd_d;  kind_q <= kind_d;  val_q <= val_d;  pc_q <= pc_d;
      head_q <= head_d;  tail_q <= tail_d;  cnt_q <= cnt_d;
      commit_q <= commit_d;  commit_store_q <= commit_store_d;  rollback_q <= rollback_d;
      commit_rd_q <= commit_rd_d;  commit_val_q <= commit_val_d;
      commit_pos_q <= commit_pos_d;  rollback_pc_q <= rollback_pc_d;
    end
  end

  assign commit         = commit_q;
  assign commit_rd      = commit_rd_q;
  assign commit_val     = commit_val_q;
  assign commit_rob_pos = commit_pos_q;
  assign commit_store   = commit_store_q;
  assign rollback       = rollback_q;
  assign rollback_pc    = rollback_pc_q;
endmodule
